// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR Fibonacci PRBS generator/checker pair:
// polynomial tap masks, checker state encoding and legal width range.
package prbs_pkg;

   localparam int MIN_N = 3;
   localparam int MAX_N = 32;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } prbs_state_t;

   // Bit i of the mask selects register bit i ([0] newest) into the XNOR feedback.
   function automatic logic [31:0] lfsr_taps(input int n);
      case (n)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream input and lock/error-statistics output bundle of the PRBS checker.
interface prbs_checker_if #(
   parameter int CNT_W = 16
);

   logic             clk_en_i;
   logic             data_i;
   logic             clr_i;
   logic             lock_o;
   logic             err_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic [CNT_W-1:0] bit_cnt_o;

   modport master (
      output clk_en_i, data_i, clr_i,
      input  lock_o, err_o, err_cnt_o, bit_cnt_o
   );

   modport slave (
      input  clk_en_i, data_i, clr_i,
      output lock_o, err_o, err_cnt_o, bit_cnt_o
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] cntBase;

   always_comb begin
      cntBase = clr_i ? '0 : cnt_q;
      cnt_d   = cntBase;
      if (inc_i && (cntBase != '1)) begin
         cnt_d = cntBase + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: searches for LOCK_CNT consecutive predicted
// bits, then free-runs its reference and counts errors until too many per window.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int N        = 8,
   parameter int LOCK_CNT = 16,
   parameter int LOSS_ERR = 4,
   parameter int LOSS_WIN = 64,
   parameter int CNT_W    = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   prbs_checker_if.slave bus
);

   localparam logic [31:0]  TAPS_FULL = lfsr_taps(N);
   localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(LOSS_WIN);
   localparam int EW = $clog2(LOSS_ERR + 1);

   if ((N < MIN_N) || (N > MAX_N)) begin : gBadN
      $error("prbs_checker: N must lie in 3..32");
   end
   if (LOSS_ERR < 1) begin : gBadLossErr
      $error("prbs_checker: LOSS_ERR must be at least 1");
   end
   if (LOSS_WIN <= LOSS_ERR) begin : gBadLossWin
      $error("prbs_checker: LOSS_WIN must exceed LOSS_ERR");
   end

   prbs_state_t   state_q, state_d;
   logic [N-1:0]  shReg_q, shReg_d;
   logic [MW-1:0] matchCnt_q, matchCnt_d;
   logic [WW-1:0] winCnt_q, winCnt_d;
   logic [EW-1:0] winErr_q, winErr_d;
   logic          err_q, err_d;

   logic          expBit;
   logic          bitErr;
   logic [EW-1:0] winErrSum;
   logic          bitInc;
   logic          errInc;

   assign expBit    = ~^(shReg_q & TAPS);
   assign bitErr    = (bus.data_i != expBit);
   assign winErrSum = winErr_q + EW'(bitErr);

   // The all-ones register is the XNOR lock-up state and never counts as a match.
   always_comb begin
      state_d    = state_q;
      shReg_d    = shReg_q;
      matchCnt_d = matchCnt_q;
      winCnt_d   = winCnt_q;
      winErr_d   = winErr_q;
      err_d      = 1'b0;
      if (bus.clk_en_i) begin
         unique case (state_q)
            SEARCH: begin
               shReg_d = {shReg_q[N-2:0], bus.data_i};
               if (!bitErr && (shReg_q != '1)) begin
                  if (matchCnt_q == MW'(LOCK_CNT - 1)) begin
                     state_d    = LOCKED;
                     matchCnt_d = '0;
                     winCnt_d   = '0;
                     winErr_d   = '0;
                  end else begin
                     matchCnt_d = matchCnt_q + 1'b1;
                  end
               end else begin
                  matchCnt_d = '0;
               end
            end
            LOCKED: begin
               err_d = bitErr;
               if (winErrSum == EW'(LOSS_ERR)) begin
                  state_d    = SEARCH;
                  matchCnt_d = '0;
                  winCnt_d   = '0;
                  winErr_d   = '0;
                  shReg_d    = {shReg_q[N-2:0], bus.data_i};
               end else begin
                  shReg_d = {shReg_q[N-2:0], expBit};
                  if (winCnt_q == WW'(LOSS_WIN - 1)) begin
                     winCnt_d = '0;
                     winErr_d = '0;
                  end else begin
                     winCnt_d = winCnt_q + 1'b1;
                     winErr_d = winErrSum;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= SEARCH;
         shReg_q    <= '0;
         matchCnt_q <= '0;
         winCnt_q   <= '0;
         winErr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shReg_q    <= shReg_d;
         matchCnt_q <= matchCnt_d;
         winCnt_q   <= winCnt_d;
         winErr_q   <= winErr_d;
         err_q      <= err_d;
      end
   end

   assign bitInc = bus.clk_en_i && (state_q == LOCKED);
   assign errInc = bitInc && bitErr;

   sat_counter #(.W(CNT_W)) uErrCnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (bus.clr_i),
      .inc_i   (errInc),
      .cnt_o   (bus.err_cnt_o)
   );

   sat_counter #(.W(CNT_W)) uBitCnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (bus.clr_i),
      .inc_i   (bitInc),
      .cnt_o   (bus.bit_cnt_o)
   );

   assign bus.lock_o = (state_q == LOCKED);
   assign bus.err_o  = err_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench: two checkers (16-bit and 4-bit counters) share one N=8
// stream; expected responses are queued per cycle and compared by a monitor.
module tb_prbs_checker;

   typedef struct {
      logic lock;
      logic err;
      int   errCnt;
      int   bitCnt;
      logic chkLock;
      logic chkBit;
   } exp_t;

   logic       clk  = 1'b0;
   logic       rstN = 1'b1;
   int         compared   = 0;
   int         mismatched = 0;
   exp_t       q[$];
   logic [7:0] genReg = 8'h00;

   prbs_checker_if #(.CNT_W(16)) busA ();
   prbs_checker_if #(.CNT_W(4))  busB ();

   prbs_checker #(.N(8), .LOCK_CNT(16), .LOSS_ERR(4), .LOSS_WIN(64), .CNT_W(16)) dutA (
      .clk_i   (clk),
      .rst_n_i (rstN),
      .bus     (busA)
   );

   prbs_checker #(.N(8), .LOCK_CNT(16), .LOSS_ERR(4), .LOSS_WIN(64), .CNT_W(4)) dutB (
      .clk_i   (clk),
      .rst_n_i (rstN),
      .bus     (busB)
   );

   always #5 clk = ~clk;

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   function automatic exp_t mkExp(input logic lock, input logic err, input int errCnt,
                                  input int bitCnt, input logic chkLock, input logic chkBit);
      exp_t e;
      e.lock    = lock;
      e.err     = err;
      e.errCnt  = errCnt;
      e.bitCnt  = bitCnt;
      e.chkLock = chkLock;
      e.chkBit  = chkBit;
      return e;
   endfunction

   // Independent N=8 XNOR generator, taps 7,5,4,3; output is the inserted bit.
   task automatic nextBit(output logic b);
      b      = ~^(genReg & 8'hB8);
      genReg = {genReg[6:0], b};
   endtask

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      if (e.chkLock) begin
         cmp("lockA", 32'(busA.lock_o), 32'(e.lock));
         cmp("lockB", 32'(busB.lock_o), 32'(e.lock));
      end
      cmp("errA", 32'(busA.err_o), 32'(e.err));
      cmp("errB", 32'(busB.err_o), 32'(e.err));
      cmp("errCntA", 32'(busA.err_cnt_o), e.errCnt);
      cmp("errCntB", 32'(busB.err_cnt_o), sat4(e.errCnt));
      if (e.chkBit) begin
         cmp("bitCntA", 32'(busA.bit_cnt_o), e.bitCnt);
         cmp("bitCntB", 32'(busB.bit_cnt_o), sat4(e.bitCnt));
      end
   endtask

   task automatic applyStimulus(input logic en, input logic d, input logic clr, input exp_t e);
      busA.clk_en_i = en;
      busB.clk_en_i = en;
      busA.data_i   = d;
      busB.data_i   = d;
      busA.clr_i    = clr;
      busB.clr_i    = clr;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Asserts reset away from any edge and checks outputs clear before the next clock.
   task automatic doReset();
      @(negedge clk);
      #1;
      busA.clk_en_i = 1'b0;
      busB.clk_en_i = 1'b0;
      busA.clr_i    = 1'b0;
      busB.clr_i    = 1'b0;
      rstN = 1'b0;
      #1;
      checkOutput(mkExp(1'b0, 1'b0, 0, 0, 1'b1, 1'b1));
      repeat (2) @(posedge clk);
      #1;
      rstN   = 1'b1;
      genReg = 8'h00;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            checkOutput(e);
         end
      end
   end

   initial begin : stimulus
      logic b, en, clr, flip, lockExp;
      int   errC, bitC, nEn;

      busA.clk_en_i = 1'b0;
      busB.clk_en_i = 1'b0;
      busA.data_i   = 1'b0;
      busB.data_i   = 1'b0;
      busA.clr_i    = 1'b0;
      busB.clr_i    = 1'b0;

      // Aligned clean stream: lock after bit 16, 984 locked bits counted.
      doReset();
      errC = 0;
      bitC = 0;
      for (int i = 1; i <= 1000; i++) begin
         nextBit(b);
         bitC = (i > 16) ? i - 16 : 0;
         applyStimulus(1'b1, b, 1'b0, mkExp(i >= 16, 1'b0, 0, bitC, 1'b1, 1'b1));
      end

      // Single flip, no propagation; then finish the current 64-bit window (locked bit 1024).
      for (int i = 1; i <= 40; i++) begin
         nextBit(b);
         flip = (i == 5);
         bitC++;
         errC += int'(flip);
         applyStimulus(1'b1, b ^ flip, 1'b0, mkExp(1'b1, flip, errC, bitC, 1'b1, 1'b1));
      end

      // Three flips per window (one on the last bit) hold lock; four drop it on the 4th.
      for (int w = 0; w < 4; w++) begin
         for (int p = 1; p <= 64; p++) begin
            nextBit(b);
            flip = (w < 3) ? (p == 10 || p == 30 || p == 64)
                           : (p == 5 || p == 20 || p == 40 || p == 64);
            lockExp = !((w == 3) && (p == 64));
            bitC++;
            errC += int'(flip);
            applyStimulus(1'b1, b ^ flip, 1'b0, mkExp(lockExp, flip, errC, bitC, 1'b1, 1'b1));
         end
      end

      // Stuck-at-1 then stuck-at-0: never locks.
      doReset();
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'b1, (i < 500), 1'b0, mkExp(1'b0, 1'b0, 0, 0, 1'b1, 1'b1));
      end

      // Phase offset (stream starts at bit 137) with random enable gaps.
      doReset();
      repeat (136) nextBit(b);
      nEn  = 0;
      errC = 0;
      for (int c = 0; c < 400 && nEn < 40; c++) begin
         en = 1'($urandom_range(0, 1));
         if (en) begin
            nextBit(b);
            nEn++;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         applyStimulus(en, b, 1'b0, mkExp(1'b1, 1'b0, 0, 0, nEn >= 24, 1'b0));
      end
      nextBit(b);
      bitC = 1;
      applyStimulus(1'b1, b, 1'b1, mkExp(1'b1, 1'b0, 0, bitC, 1'b1, 1'b1));
      for (int c = 0; c < 30; c++) begin
         en  = (c == 10) ? 1'b0 : 1'($urandom_range(0, 1));
         clr = (c == 10);
         if (clr) bitC = 0;
         if (en) begin
            nextBit(b);
            bitC++;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         applyStimulus(en, b, clr, mkExp(1'b1, 1'b0, 0, bitC, 1'b1, 1'b1));
      end

      // 20 isolated errors (22 bits apart): 4-bit counter saturates at 15.
      for (int k = 0; k < 470; k++) begin
         nextBit(b);
         flip = (k < 440) && ((k % 22) == 21);
         bitC++;
         errC += int'(flip);
         applyStimulus(1'b1, b ^ flip, 1'b0, mkExp(1'b1, flip, errC, bitC, 1'b1, 1'b1));
      end

      // Clear on an errored bit leaves both counters at 1.
      nextBit(b);
      errC = 1;
      bitC = 1;
      applyStimulus(1'b1, ~b, 1'b1, mkExp(1'b1, 1'b1, errC, bitC, 1'b1, 1'b1));

      // Reset while locked with nonzero counters.
      doReset();

      cmp("queueDrained", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Serial pseudo-random bit-sequence checker, the receive end of the team's XNOR Fibonacci LFSR pattern generator.
- Self-synchronises to an incoming 1-bit PRBS stream using the same N-bit polynomial.
- Declares lock, then free-runs its own reference and counts bit errors for link BER tests in the CDR datapath.
- Drops lock on excessive errors and re-searches.

Parameters:
N, 8, LFSR width / polynomial order; legal values 3..32.
LOCK_CNT, 16, consecutive matching bits needed to declare lock.
LOSS_ERR, 4, errors within one window that cause loss of lock.
LOSS_WIN, 64, window length in enabled bits.
CNT_W, 16, width of the error and bit counters.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset, asynchronous, active-low
clk_en_i  input  1  bit valid; data_i is sampled only when high
data_i  input  1  received PRBS bit
clr_i  input  1  synchronous clear of err_cnt_o and bit_cnt_o
lock_o  output  1  checker locked to the stream
err_o  output  1  one-cycle pulse per errored bit while locked
err_cnt_o  output  CNT_W  saturating error count, locked bits only
bit_cnt_o  output  CNT_W  saturating count of bits checked while locked

Behaviour:
- Reset values: state SEARCH, shreg 0, match_cnt 0, win_cnt 0, win_err 0, all outputs 0.
- Stream convention: each enabled bit equals the generator's newly inserted bit, i.e. its register bit 0 after the update.
- shreg layout matches the generator: shreg <= {shreg[N-2:0], b}, where [0] is newest and [N-1] is oldest.
- Expected bit e is the XNOR over the tap set for N applied to shreg. Tap table (indices into shreg):
  3:2,1  4:3,2  5:4,2  6:5,4  7:6,5  8:7,5,4,3  9:8,4  10:9,6  11:10,8  12:11,5,3,0
  13:12,3,2,0  14:13,4,2,0  15:14,13  16:15,14,12,3  17:16,13  18:17,10  19:18,5,1,0  20:19,16
  21:20,18  22:21,20  23:22,17  24:23,22,21,16  25:24,21  26:25,5,1,0  27:26,4,1,0  28:27,24
  29:28,26  30:29,5,3,0  31:30,27  32:31,21,1,0
- clk_en_i=0: no state, shreg or counter change; err_o=0.
- SEARCH, on enabled bit:
  - shreg <= {shreg, data_i}.
  - If data_i==e and shreg != all-ones, match_cnt++; otherwise match_cnt <= 0.
  - All-ones is the XNOR lock-up state and must never count toward lock.
  - On the LOCK_CNT-th consecutive match: state <= LOCKED, lock_o=1 the next cycle, win_cnt and win_err cleared.
- LOCKED, on enabled bit:
  - shreg <= {shreg, e}: the reference free-runs, so a received error never propagates.
  - err = (data_i != e). err_o <= err (registered, one cycle after sampling).
  - bit_cnt_o++ and, if err, err_cnt_o++. Both saturate at all-ones.
  - win_err += err; win_cnt++.
  - If win_err reaches LOSS_ERR, including via the current bit: state <= SEARCH, lock_o <= 0, match_cnt <= 0, shreg <= {shreg, data_i}.
  - Otherwise, when win_cnt==LOSS_WIN-1, clear win_cnt and win_err. The last bit's error is checked for loss before the window clears.
- clr_i: clears err_cnt_o/bit_cnt_o in any state. If clr_i coincides with a counted event, the counter becomes 1 (clear first, then count).
- Reset asserted mid-operation returns to reset values immediately; no output glitch is held.
- Latency: lock_o rises 1 cycle after the locking bit; err_o is 1 cycle after the errored bit.

Decomposition:
- Package prbs_pkg:
  - function lfsr_taps(int n) returning a 32-bit tap mask (table above), shared with the generator;
  - typedef enum logic {SEARCH, LOCKED} prbs_state_t;
  - localparam MIN_N=3, MAX_N=32.
- Sub-module sat_counter #(W): increment, clear and saturation with the clear-then-count rule; instantiated twice.
- Elaboration-time assertion:
  - N in 3..32;
  - LOSS_ERR >= 1;
  - LOSS_WIN > LOSS_ERR.

Test Plan:
1. Aligned clean stream: N=8 generator and checker released together, clk_en_i=1 for 1000 bits -> lock_o=1 from the cycle after bit 16; err_cnt_o=0; bit_cnt_o=984.
2. Phase offset and enable gaps: stream starts at generator bit 137, clk_en_i random 50% -> lock within N+16 enabled bits; no counter moves on disabled cycles.
3. Single bit flip while locked -> exactly one err_o pulse; err_cnt_o=1; lock_o stays 1; following bits error-free (no propagation).
4. Four flips within 64 bits -> lock_o falls the cycle after the 4th flip. Three flips per window, repeated -> lock held.
5. Stuck-at-1 and stuck-at-0 inputs for 500 bits each -> lock_o never rises.
6. CNT_W=4, 20 isolated errors -> err_cnt_o saturates at 15; clr_i on an errored bit -> 1; rst_n_i low while locked -> all outputs 0 immediately.
